// File: rtl/can_frame_if.sv
// Bus-side bundle for the CAN receive frame decoder: serial input, sample
// strobe and the decoded field outputs.
interface can_frame_if;
  logic        rx_bit;
  logic        sample_point;
  logic        field_start_of_frame;
  logic [10:0] field_id_a;
  logic        field_ide;
  logic        field_rtr;
  logic        field_srr;
  logic        field_reserved1;
  logic        field_reserved0;
  logic [17:0] field_id_b;
  logic [3:0]  field_dlc;
  logic [63:0] field_data;
  logic [14:0] field_crc;
  logic        field_crc_delimiter;
  logic        field_ack_slot;
  logic        field_ack_delimiter;
  logic        rtr_srr_temp;

  modport master (
    output rx_bit, sample_point,
    input  field_start_of_frame, field_id_a, field_ide, field_rtr, field_srr,
           field_reserved1, field_reserved0, field_id_b, field_dlc, field_data,
           field_crc, field_crc_delimiter, field_ack_slot, field_ack_delimiter,
           rtr_srr_temp
  );

  modport slave (
    input  rx_bit, sample_point,
    output field_start_of_frame, field_id_a, field_ide, field_rtr, field_srr,
           field_reserved1, field_reserved0, field_id_b, field_dlc, field_data,
           field_crc, field_crc_delimiter, field_ack_slot, field_ack_delimiter,
           rtr_srr_temp
  );
endinterface

// File: rtl/can_frame_decoder.sv
// Receive-side CAN 2.0A/2.0B frame parser: one bit per sample strobe,
// de-stuffs SOF..CRC and splits the frame into registered fields.
module can_frame_decoder #(
  parameter int EOF_LEN   = 7,
  parameter int MAX_BYTES = 8
) (
  input  logic     clk,
  input  logic     rst,
  can_frame_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID_A, S_RTR_SRR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0,
    S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF
  } state_t;

  localparam logic [4:0] MAXB    = 5'(MAX_BYTES);
  localparam logic [6:0] EOF_END = 7'(EOF_LEN - 1);

  state_t      state;
  logic        sp_q;
  logic [6:0]  cnt;
  logic [2:0]  stuff_cnt;
  logic        last_bit;
  logic [6:0]  dbits;

  logic        sof_r;
  logic [10:0] id_a_r;
  logic        ide_r;
  logic        rtr_r;
  logic        srr_r;
  logic        r1_r;
  logic        r0_r;
  logic [17:0] id_b_r;
  logic [3:0]  dlc_r;
  logic [63:0] data_r;
  logic [14:0] crc_r;
  logic        crc_del_r;
  logic        ack_r;
  logic        ack_del_r;
  logic        rtr_srr_r;

  logic        smp;
  logic        b;
  logic        destuff_zone;
  logic        stuff_slot;
  logic [3:0]  dlc_next;
  logic [3:0]  nbytes;
  logic [6:0]  dbits_next;

  assign smp          = bus.sample_point & ~sp_q;
  assign b            = bus.rx_bit;
  assign destuff_zone = (state != S_IDLE) && (state != S_CRC_DEL) && (state != S_ACK_SLOT) &&
                        (state != S_ACK_DEL) && (state != S_EOF);
  assign stuff_slot   = destuff_zone && (stuff_cnt == 3'd5);

  // Data length resolved on the last DLC bit; remote frames carry no data.
  assign dlc_next   = {dlc_r[2:0], b};
  assign nbytes     = ({1'b0, dlc_next} > MAXB) ? MAXB[3:0] : dlc_next;
  assign dbits_next = rtr_r ? 7'd0 : {nbytes, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      sp_q      <= 1'b1;
      cnt       <= '0;
      stuff_cnt <= '0;
      last_bit  <= 1'b0;
      dbits     <= '0;
      sof_r     <= 1'b0;
      id_a_r    <= '0;
      ide_r     <= 1'b0;
      rtr_r     <= 1'b0;
      srr_r     <= 1'b0;
      r1_r      <= 1'b0;
      r0_r      <= 1'b0;
      id_b_r    <= '0;
      dlc_r     <= '0;
      data_r    <= '0;
      crc_r     <= '0;
      crc_del_r <= 1'b0;
      ack_r     <= 1'b0;
      ack_del_r <= 1'b0;
      rtr_srr_r <= 1'b0;
    end else begin
      sp_q <= bus.sample_point;
      if (smp) begin
        if (stuff_slot) begin
          // Stuff bit must be the complement of the run it breaks.
          if (b == last_bit) begin
            state <= S_IDLE;
            sof_r <= 1'b0;
          end else begin
            last_bit  <= b;
            stuff_cnt <= 3'd1;
          end
        end else begin
          if (destuff_zone) begin
            if (b == last_bit) begin
              stuff_cnt <= stuff_cnt + 3'd1;
            end else begin
              stuff_cnt <= 3'd1;
              last_bit  <= b;
            end
          end
          case (state)
            S_IDLE: begin
              if (!b) begin
                state     <= S_ID_A;
                cnt       <= '0;
                stuff_cnt <= 3'd1;
                last_bit  <= 1'b0;
                dbits     <= '0;
                sof_r     <= 1'b1;
                id_a_r    <= '0;
                ide_r     <= 1'b0;
                rtr_r     <= 1'b0;
                srr_r     <= 1'b0;
                r1_r      <= 1'b0;
                r0_r      <= 1'b0;
                id_b_r    <= '0;
                dlc_r     <= '0;
                data_r    <= '0;
                crc_r     <= '0;
                crc_del_r <= 1'b0;
                ack_r     <= 1'b0;
                ack_del_r <= 1'b0;
                rtr_srr_r <= 1'b0;
              end
            end
            S_ID_A: begin
              id_a_r <= {id_a_r[9:0], b};
              if (cnt == 7'd10) begin
                cnt   <= '0;
                state <= S_RTR_SRR;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
            S_RTR_SRR: begin
              rtr_srr_r <= b;
              state     <= S_IDE;
            end
            S_IDE: begin
              ide_r <= b;
              if (b) begin
                srr_r <= rtr_srr_r;
                state <= S_ID_B;
              end else begin
                rtr_r <= rtr_srr_r;
                state <= S_R0;
              end
            end
            S_ID_B: begin
              id_b_r <= {id_b_r[16:0], b};
              if (cnt == 7'd17) begin
                cnt   <= '0;
                state <= S_RTR;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
            S_RTR: begin
              rtr_r <= b;
              state <= S_R1;
            end
            S_R1: begin
              r1_r  <= b;
              state <= S_R0;
            end
            S_R0: begin
              r0_r  <= b;
              cnt   <= '0;
              state <= S_DLC;
            end
            S_DLC: begin
              dlc_r <= dlc_next;
              if (cnt == 7'd3) begin
                cnt   <= '0;
                dbits <= dbits_next;
                state <= (dbits_next == 7'd0) ? S_CRC : S_DATA;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
            S_DATA: begin
              data_r <= {data_r[62:0], b};
              if (cnt == dbits - 7'd1) begin
                cnt   <= '0;
                state <= S_CRC;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
            S_CRC: begin
              crc_r <= {crc_r[13:0], b};
              if (cnt == 7'd14) begin
                cnt   <= '0;
                state <= S_CRC_DEL;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
            S_CRC_DEL: begin
              crc_del_r <= b;
              state     <= S_ACK_SLOT;
            end
            S_ACK_SLOT: begin
              ack_r <= b;
              state <= S_ACK_DEL;
            end
            S_ACK_DEL: begin
              ack_del_r <= b;
              cnt       <= '0;
              state     <= S_EOF;
            end
            S_EOF: begin
              // A dominant bit here ends the frame early as well.
              if (!b || cnt == EOF_END) begin
                cnt   <= '0;
                state <= S_IDLE;
                sof_r <= 1'b0;
              end else begin
                cnt <= cnt + 7'd1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.field_start_of_frame = sof_r;
  assign bus.field_id_a           = id_a_r;
  assign bus.field_ide            = ide_r;
  assign bus.field_rtr            = rtr_r;
  assign bus.field_srr            = srr_r;
  assign bus.field_reserved1      = r1_r;
  assign bus.field_reserved0      = r0_r;
  assign bus.field_id_b           = id_b_r;
  assign bus.field_dlc            = dlc_r;
  assign bus.field_data           = data_r;
  assign bus.field_crc            = crc_r;
  assign bus.field_crc_delimiter  = crc_del_r;
  assign bus.field_ack_slot       = ack_r;
  assign bus.field_ack_delimiter  = ack_del_r;
  assign bus.rtr_srr_temp         = rtr_srr_r;

endmodule

// File: tb/tb_can_frame_decoder.sv
// Bench for can_frame_decoder: frames are assembled from field values,
// bit-stuffed, serialised on the strobe and the decoded fields compared.
module tb_can_frame_decoder;
  localparam int MAX_BYTES = 8;
  localparam int EOF_LEN   = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  can_frame_if bus ();

  can_frame_decoder #(.EOF_LEN(EOF_LEN), .MAX_BYTES(MAX_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit        ide;
    bit [10:0] id_a;
    bit        srr;
    bit [17:0] id_b;
    bit        rtr;
    bit        r1;
    bit        r0;
    bit [3:0]  dlc;
    bit [63:0] data;
    bit [14:0] crc;
    bit        crc_del;
    bit        ack;
    bit        ack_del;
  } frame_t;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int data_bits(input frame_t f);
    int n;
    if (f.rtr) return 0;
    n = (int'(f.dlc) > MAX_BYTES) ? MAX_BYTES : int'(f.dlc);
    return n * 8;
  endfunction

  // Frame on the wire: field bits, stuffing over SOF..CRC, then the
  // unstuffed tail. eof_break >= 0 makes that EOF bit dominant.
  task automatic build_frame(input frame_t f, input int eof_break, output bit q[$], output int tail_run);
    bit raw[$];
    int nb;
    int run;
    bit last;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(f.id_a[i]);
    if (f.ide) begin
      raw.push_back(f.srr);
      raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(f.id_b[i]);
      raw.push_back(f.rtr);
      raw.push_back(f.r1);
    end else begin
      raw.push_back(f.rtr);
      raw.push_back(1'b0);
    end
    raw.push_back(f.r0);
    for (int i = 3; i >= 0; i--) raw.push_back(f.dlc[i]);
    nb = data_bits(f);
    for (int i = nb - 1; i >= 0; i--) raw.push_back(f.data[i]);
    for (int i = 14; i >= 0; i--) raw.push_back(f.crc[i]);
    q.delete();
    run  = 0;
    last = 1'b0;
    for (int i = 0; i < raw.size(); i++) begin
      q.push_back(raw[i]);
      if (i > 0 && raw[i] == last) run++;
      else begin
        run  = 1;
        last = raw[i];
      end
      if (run == 5 && i < raw.size() - 1) begin
        q.push_back(!last);
        last = !last;
        run  = 1;
      end
    end
    tail_run = run;
    q.push_back(f.crc_del);
    q.push_back(f.ack);
    q.push_back(f.ack_del);
    for (int i = 0; i < EOF_LEN; i++) q.push_back((eof_break == i) ? 1'b0 : 1'b1);
  endtask

  task automatic send_bit(input bit b);
    bus.rx_bit = b;
    repeat (4) @(negedge clk);
    bus.sample_point = 1'b1;
    repeat (5) @(negedge clk);
    bus.sample_point = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_fields(input frame_t f);
    int nb;
    logic [63:0] exp_data;
    nb = data_bits(f);
    if (nb == 0)       exp_data = 64'd0;
    else if (nb == 64) exp_data = f.data;
    else               exp_data = f.data & ((64'd1 << nb) - 64'd1);
    check_val("id_a",    64'(bus.field_id_a), 64'(f.id_a));
    check_val("ide",     64'(bus.field_ide), 64'(f.ide));
    check_val("rtr",     64'(bus.field_rtr), 64'(f.rtr));
    check_val("srr",     64'(bus.field_srr), f.ide ? 64'(f.srr) : 64'd0);
    check_val("rtr_srr_temp", 64'(bus.rtr_srr_temp), f.ide ? 64'(f.srr) : 64'(f.rtr));
    check_val("r1",      64'(bus.field_reserved1), f.ide ? 64'(f.r1) : 64'd0);
    check_val("r0",      64'(bus.field_reserved0), 64'(f.r0));
    check_val("id_b",    64'(bus.field_id_b), f.ide ? 64'(f.id_b) : 64'd0);
    check_val("dlc",     64'(bus.field_dlc), 64'(f.dlc));
    check_val("data",    bus.field_data, exp_data);
    check_val("crc",     64'(bus.field_crc), 64'(f.crc));
    check_val("crc_del", 64'(bus.field_crc_delimiter), 64'(f.crc_del));
    check_val("ack",     64'(bus.field_ack_slot), 64'(f.ack));
    check_val("ack_del", 64'(bus.field_ack_delimiter), 64'(f.ack_del));
  endtask

  task automatic send_frame(input frame_t f, input int eof_break);
    bit q[$];
    int tr;
    int eof0;
    build_frame(f, eof_break, q, tr);
    eof0 = q.size() - EOF_LEN;
    send_bit(q[0]);
    check_val("sof_set", 64'(bus.field_start_of_frame), 64'd1);
    if (eof_break < 0) begin
      for (int i = 1; i < q.size() - 1; i++) send_bit(q[i]);
      check_val("sof_in_eof", 64'(bus.field_start_of_frame), 64'd1);
      send_bit(q[q.size() - 1]);
      check_val("sof_fall", 64'(bus.field_start_of_frame), 64'd0);
    end else begin
      for (int i = 1; i <= eof0 + eof_break; i++) send_bit(q[i]);
      check_val("sof_eof_break", 64'(bus.field_start_of_frame), 64'd0);
      for (int i = eof0 + eof_break + 1; i < q.size(); i++) send_bit(q[i]);
    end
    check_fields(f);
    repeat (3) send_bit(1'b1);
  endtask

  frame_t f_std, f_ext, f_rem, f_d15, f_rnd;
  bit     qq[$];
  int     tr;

  initial begin
    bus.rx_bit       = 1'b1;
    bus.sample_point = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_sof",  64'(bus.field_start_of_frame), 64'd0);
    check_val("rst_id_a", 64'(bus.field_id_a), 64'd0);
    check_val("rst_data", bus.field_data, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.sample_point = 1'b0;
    @(negedge clk);
    check_val("no_spurious_sof", 64'(bus.field_start_of_frame), 64'd0);
    repeat (2) send_bit(1'b1);

    f_std = '{ide:0, id_a:11'h123, srr:0, id_b:0, rtr:0, r1:0, r0:0, dlc:4'd1,
              data:64'hA5, crc:15'h1ABC, crc_del:1, ack:0, ack_del:1};
    send_frame(f_std, -1);

    f_ext = '{ide:1, id_a:11'h449, srr:1, id_b:18'h2AAAA, rtr:0, r1:0, r0:0, dlc:4'd2,
              data:64'h1234, crc:15'h2D3C, crc_del:1, ack:0, ack_del:1};
    send_frame(f_ext, -1);

    f_rem = '{ide:0, id_a:11'h321, srr:0, id_b:0, rtr:1, r1:0, r0:0, dlc:4'd4,
              data:64'hDEADBEEF, crc:15'h4A5B, crc_del:1, ack:0, ack_del:1};
    send_frame(f_rem, -1);

    f_d15 = '{ide:0, id_a:11'h7F0, srr:0, id_b:0, rtr:0, r1:0, r0:1, dlc:4'd15,
              data:64'h0102030405060708, crc:15'h3C3C, crc_del:1, ack:0, ack_del:1};
    send_frame(f_d15, -1);

    send_frame(f_std, 2);
    repeat (8) send_bit(1'b1);

    // SOF, one recessive ID bit, then six dominant bits: the sixth sits in a stuff slot.
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    check_val("stuff_pre_sof", 64'(bus.field_start_of_frame), 64'd1);
    send_bit(1'b0);
    check_val("stuff_err_sof", 64'(bus.field_start_of_frame), 64'd0);
    check_val("stuff_err_id_a", 64'(bus.field_id_a), 64'h20);
    repeat (11) send_bit(1'b1);
    check_val("stuff_idle", 64'(bus.field_start_of_frame), 64'd0);
    send_frame(f_ext, -1);

    // Reset pulse while data bits are streaming in.
    build_frame(f_d15, -1, qq, tr);
    for (int i = 0; i < 32; i++) send_bit(qq[i]);
    check_val("pre_rst_sof", 64'(bus.field_start_of_frame), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_val("midrst_sof",  64'(bus.field_start_of_frame), 64'd0);
    check_val("midrst_id_a", 64'(bus.field_id_a), 64'd0);
    check_val("midrst_dlc",  64'(bus.field_dlc), 64'd0);
    check_val("midrst_data", bus.field_data, 64'd0);
    check_val("midrst_r0",   64'(bus.field_reserved0), 64'd0);
    repeat (6) send_bit(1'b1);
    check_val("midrst_idle", 64'(bus.field_start_of_frame), 64'd0);
    send_frame(f_std, -1);

    for (int n = 0; n < 18; n++) begin
      f_rnd.ide     = 1'($urandom);
      f_rnd.id_a    = 11'($urandom);
      f_rnd.srr     = 1'($urandom);
      f_rnd.id_b    = 18'($urandom);
      f_rnd.rtr     = ($urandom_range(0, 3) == 0);
      f_rnd.r1      = 1'($urandom);
      f_rnd.r0      = 1'($urandom);
      f_rnd.dlc     = 4'($urandom);
      f_rnd.data    = {$urandom, $urandom};
      f_rnd.crc_del = 1'($urandom);
      f_rnd.ack     = 1'($urandom);
      f_rnd.ack_del = 1'($urandom);
      do begin
        f_rnd.crc = 15'($urandom);
        build_frame(f_rnd, -1, qq, tr);
      end while (tr == 5);
      send_frame(f_rnd, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
